// File: rtl/gps_seq_pkg.sv
// Shared types for the GPS sweep sequencer: FSM states, result entry layout
// and the SV wrap helper.
package gps_seq_pkg;

  localparam int SV_W   = 6;
  localparam int CA_W   = 13;
  localparam int CODE_W = 128;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ARM   = 3'd2,
    WAIT  = 3'd3,
    STORE = 3'd4
  } state_t;

  // 6 + 13 + 128 + 128 + 1 = 276 bits
  typedef struct packed {
    logic [SV_W-1:0]   sv;
    logic [CA_W-1:0]   ca;
    logic [CODE_W-1:0] p;
    logic [CODE_W-1:0] l;
    logic              err;
  } entry_t;

  function automatic logic [SV_W-1:0] sv_next(input logic [SV_W-1:0] cur,
                                               input logic [SV_W-1:0] sv_max);
    return (cur >= sv_max) ? SV_W'(1) : cur + SV_W'(1);
  endfunction

endpackage

// File: rtl/gps_seq_fifo.sv
// First-word-fall-through result FIFO; head fields read as zero while empty.
module gps_seq_fifo
  import gps_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign do_push = push && (count != FULL);
  assign do_pop  = pop && valid;
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gps_sweep_sequencer.sv
// Sweeps a range of GPS SVs, one code-generation round each, buffering results.
// Optional per-round wait limit enabled by defining GPS_SEQ_TIMEOUT_EN.
module gps_sweep_sequencer
  import gps_seq_pkg::*;
#(
  parameter int SV_MAX      = 37,
  parameter int SETTLE_CYC  = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        sync_rst_in,
  input  logic                        go,
  input  logic                        abort,
  input  logic [SV_W-1:0]             first_sv,
  input  logic [SV_W-1:0]             last_sv,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err,
  output logic [SV_W-1:0]             sv_num,
  output logic                        startRound,
  input  logic [CA_W-1:0]             ca_code,
  input  logic [CODE_W-1:0]           p_code,
  input  logic [CODE_W-1:0]           l_code,
  input  logic                        l_code_valid,
  input  logic                        res_rd,
  output logic                        res_valid,
  output logic [SV_W-1:0]             res_sv,
  output logic [CA_W-1:0]             res_ca,
  output logic [CODE_W-1:0]           res_p,
  output logic [CODE_W-1:0]           res_l,
  output logic                        res_err,
  output logic [$clog2(FIFO_DEPTH):0] res_count,
  output state_t                      fsm_state
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int SET_W = $clog2(SETTLE_CYC);
  localparam logic [CW-1:0]    FULL   = CW'(FIFO_DEPTH);
  localparam logic [SV_W-1:0]  SV_LIM = SV_W'(SV_MAX);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  state_t           state;
  logic [SV_W-1:0]  cur;
  logic [SV_W-1:0]  last;
  logic [SET_W-1:0] settle_cnt;
  logic             abort_pend;
  entry_t           entry_q;
  entry_t           head;
  logic             legal;
  logic             abort_now;

`ifdef GPS_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tcnt;
`else
  localparam int unused_timeout = TIMEOUT_CYC;
`endif

  assign legal = (first_sv != '0) && (first_sv <= SV_LIM) &&
                 (last_sv  != '0) && (last_sv  <= SV_LIM);
  assign abort_now = abort || abort_pend;
  assign fsm_state = state;

  // Valid/ready: an entry is pushed only in STORE, and ARM never launches a
  // round unless a slot is free, so a push never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (sync_rst_in) begin
      state      <= IDLE;
      cur        <= '0;
      last       <= '0;
      settle_cnt <= '0;
      abort_pend <= 1'b0;
      entry_q    <= '0;
      sv_num     <= '0;
      startRound <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
`ifdef GPS_SEQ_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (abort && state != IDLE) abort_pend <= 1'b1;
      case (state)
        IDLE: begin
          abort_pend <= 1'b0;
          if (go) begin
            if (legal) begin
              cur        <= first_sv;
              last       <= last_sv;
              sv_num     <= first_sv;
              settle_cnt <= '0;
              busy       <= 1'b1;
              state      <= LOAD;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (abort_now) begin
            startRound <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            abort_pend <= 1'b0;
            state      <= IDLE;
          end else if (settle_cnt == SET_LAST) begin
            state <= ARM;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        ARM: begin
          if (abort_now) begin
            startRound <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            abort_pend <= 1'b0;
            state      <= IDLE;
          end else if (res_count != FULL) begin
            startRound <= 1'b1;
            state      <= WAIT;
`ifdef GPS_SEQ_TIMEOUT_EN
            tcnt       <= '0;
`endif
          end
        end
        WAIT: begin
          if (l_code_valid) begin
            entry_q    <= '{sv: cur, ca: ca_code, p: p_code, l: l_code, err: 1'b0};
            startRound <= 1'b0;
            state      <= STORE;
          end
`ifdef GPS_SEQ_TIMEOUT_EN
          else if (tcnt == T_LAST) begin
            entry_q    <= '{sv: cur, ca: '0, p: '0, l: '0, err: 1'b1};
            startRound <= 1'b0;
            state      <= STORE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
        STORE: begin
          if (cur == last || abort_now) begin
            done       <= 1'b1;
            busy       <= 1'b0;
            abort_pend <= 1'b0;
            state      <= IDLE;
          end else begin
            cur        <= sv_next(cur, SV_LIM);
            sv_num     <= sv_next(cur, SV_LIM);
            settle_cnt <= '0;
            state      <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  gps_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (sync_rst_in),
    .push  (state == STORE),
    .din   (entry_q),
    .pop   (res_rd),
    .head  (head),
    .valid (res_valid),
    .count (res_count)
  );

  assign res_sv = head.sv;
  assign res_ca = head.ca;
  assign res_p  = head.p;
  assign res_l  = head.l;

`ifdef GPS_SEQ_TIMEOUT_EN
  assign res_err = head.err;
`else
  logic unused_err;
  assign unused_err = head.err;
  assign res_err    = 1'b0;
`endif

endmodule

// File: tb/tb_gps_sweep_sequencer.sv
// Directed bench for gps_sweep_sequencer with a small behavioural GPS responder.
// The timeout scenario runs only when GPS_SEQ_TIMEOUT_EN is defined.
module tb_gps_sweep_sequencer;
  import gps_seq_pkg::*;

  localparam int GPS_LAT = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         sync_rst_in = 1'b1;
  logic         go = 1'b0, abort = 1'b0, res_rd = 1'b0;
  logic [5:0]   first_sv = '0, last_sv = '0;
  logic         busy, done, cfg_err, startRound, res_valid, res_err;
  logic [5:0]   sv_num, res_sv;
  logic [12:0]  ca_code = '0, res_ca;
  logic [127:0] p_code = '0, l_code = '0, res_p, res_l;
  logic         l_code_valid = 1'b0;
  logic [2:0]   res_count;
  state_t       fsm_state;

  int total = 0;
  int bad = 0;

  logic [SV_W-1:0] exp_q[$];
  logic [SV_W-1:0] got_q[$];
  logic            err_q[$];
  logic            code_q[$];

  gps_sweep_sequencer #(
    .SV_MAX(37), .SETTLE_CYC(4), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .sync_rst_in(sync_rst_in), .go(go), .abort(abort),
    .first_sv(first_sv), .last_sv(last_sv), .busy(busy), .done(done),
    .cfg_err(cfg_err), .sv_num(sv_num), .startRound(startRound),
    .ca_code(ca_code), .p_code(p_code), .l_code(l_code),
    .l_code_valid(l_code_valid), .res_rd(res_rd), .res_valid(res_valid),
    .res_sv(res_sv), .res_ca(res_ca), .res_p(res_p), .res_l(res_l),
    .res_err(res_err), .res_count(res_count), .fsm_state(fsm_state)
  );

  // reference code values produced by the GPS stand-in for a given SV
  function automatic logic [12:0] ca_of(input logic [5:0] sv);
    return 13'h1A00 + 13'(sv) * 13'd3;
  endfunction
  function automatic logic [127:0] p_of(input logic [5:0] sv);
    return {32'hC0DE_0000 | 32'(sv), 64'h0123_4567_89AB_CDEF, 32'hFFFF_0000 ^ 32'(sv)};
  endfunction
  function automatic logic [127:0] l_of(input logic [5:0] sv);
    logic [127:0] t;
    t = p_of(sv);
    return {t[63:0], ~t[127:64]};
  endfunction

  // GPS stand-in: start edge clears valid, results appear GPS_LAT cycles later
  logic       gps_mute = 1'b0;
  logic       sr_prev = 1'b0;
  int         lat = 0;
  logic [5:0] gps_sv = '0;
  always @(negedge clk) begin
    if (sync_rst_in) begin
      l_code_valid = 1'b0;
      sr_prev = 1'b0;
      lat = 0;
    end else begin
      if (startRound && !sr_prev) begin
        l_code_valid = 1'b0;
        gps_sv = sv_num;
        lat = GPS_LAT;
      end else if (lat > 0) begin
        lat--;
        if (lat == 0 && !gps_mute) begin
          l_code_valid = 1'b1;
          ca_code = ca_of(gps_sv);
          p_code = p_of(gps_sv);
          l_code = l_of(gps_sv);
        end
      end
      sr_prev = startRound;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond(input int kind, input int v);
    case (kind)
      0:       return done === 1'b1;
      1:       return int'(res_count) == v;
      2:       return startRound === 1'b1;
      default: return (fsm_state == LOAD) && (int'(sv_num) == v);
    endcase
  endfunction

  task automatic wait_for(input int kind, input int v, input int budget, input string tag);
    bit met;
    met = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cond(kind, v)) begin
        met = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, met, 1'b1);
  endtask

  task automatic pulse_go(input logic [5:0] f, input logic [5:0] l);
    first_sv = f;
    last_sv = l;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  // scoreboard: record every head entry while res_rd pops it, until done drains
  task automatic collect(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (res_valid) begin
        got_q.push_back(res_sv);
        err_q.push_back(res_err);
        code_q.push_back(|{res_ca, res_p, res_l});
      end
      if (done) seen = 1'b1;
      if (seen && !res_valid) break;
      tick();
    end
    chk("collect_done", seen, 1'b1);
  endtask

  task automatic check_q(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (i < got_q.size()) ? got_q[i] : 6'bx, exp_q[i]);
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic pop_check(input string tag, input logic [5:0] exp_sv);
    chk(tag, res_sv, exp_sv);
    res_rd = 1'b1;
    tick();
    res_rd = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_sv_num"}, sv_num, 6'd0);
    chk({tag, "_start"}, startRound, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_cfg_err"}, cfg_err, 1'b0);
    chk({tag, "_valid"}, res_valid, 1'b0);
    chk({tag, "_count"}, res_count, 3'd0);
    chk({tag, "_res_sv"}, res_sv, 6'd0);
    chk({tag, "_res_l"}, res_l, 128'd0);
    chk({tag, "_state"}, fsm_state, IDLE);
  endtask

  initial begin
    int n;
    // reset
    repeat (3) tick();
    check_reset_values("rst");
    sync_rst_in = 1'b0;
    tick();

    // basic single round on SV 5
    pulse_go(6'd5, 6'd5);
    chk("basic_busy", busy, 1'b1);
    chk("basic_sv_num", sv_num, 6'd5);
    chk("basic_start_low", startRound, 1'b0);
    n = 0;
    while (!startRound && n < 50) begin
      tick();
      n++;
    end
    chk("basic_launch_lat", n, 5);
    wait_for(0, 0, 100, "basic_done_wait");
    chk("basic_count", res_count, 3'd1);
    chk("basic_busy_low", busy, 1'b0);
    chk("basic_res_sv", res_sv, 6'd5);
    chk("basic_res_ca", res_ca, ca_of(6'd5));
    chk("basic_res_p", res_p, p_of(6'd5));
    chk("basic_res_l", res_l, l_of(6'd5));
    chk("basic_res_err", res_err, 1'b0);
    tick();
    chk("basic_done_pulse", done, 1'b0);
    res_rd = 1'b1;
    tick();
    res_rd = 1'b0;
    chk("basic_pop_valid", res_valid, 1'b0);
    chk("basic_pop_count", res_count, 3'd0);

    // wrap sweep 36 -> 2 with continuous draining
    res_rd = 1'b1;
    pulse_go(6'd36, 6'd2);
    collect(400);
    res_rd = 1'b0;
    exp_q = '{6'd36, 6'd37, 6'd1, 6'd2};
    check_q("wrap_order");
    err_q.delete();
    code_q.delete();
    tick();
    chk("wrap_empty", res_count, 3'd0);

    // backpressure: sweep 1..6 without reading
    pulse_go(6'd1, 6'd6);
    wait_for(1, 4, 300, "bp_fill_wait");
    repeat (20) tick();
    chk("bp_state_arm", fsm_state, ARM);
    chk("bp_start_low", startRound, 1'b0);
    chk("bp_count_full", res_count, 3'd4);
    chk("bp_busy", busy, 1'b1);
    first_sv = 6'd0;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    chk("bp_go_busy_no_err", cfg_err, 1'b0);
    pop_check("bp_head_sv1", 6'd1);
    wait_for(2, 0, 20, "bp_launch_wait");
    chk("bp_launch_sv5", sv_num, 6'd5);
    res_rd = 1'b1;
    collect(400);
    res_rd = 1'b0;
    exp_q = '{6'd2, 6'd3, 6'd4, 6'd5, 6'd6};
    check_q("bp_order");
    err_q.delete();
    code_q.delete();
    tick();
    chk("bp_empty", res_count, 3'd0);

    // illegal configurations
    pulse_go(6'd0, 6'd5);
    chk("ill0_cfg_err", cfg_err, 1'b1);
    chk("ill0_busy", busy, 1'b0);
    chk("ill0_state", fsm_state, IDLE);
    tick();
    chk("ill0_pulse", cfg_err, 1'b0);
    pulse_go(6'd1, 6'd38);
    chk("ill38_cfg_err", cfg_err, 1'b1);
    chk("ill38_busy", busy, 1'b0);
    chk("ill38_count", res_count, 3'd0);
    tick();
    chk("ill38_pulse", cfg_err, 1'b0);

    // abort during LOAD of SV 3 in a 1..10 sweep
    pulse_go(6'd1, 6'd10);
    wait_for(3, 3, 200, "abort_wait_load3");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_done", done, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_count", res_count, 3'd2);
    chk("abort_start", startRound, 1'b0);
    chk("abort_state", fsm_state, IDLE);
    tick();
    chk("abort_done_pulse", done, 1'b0);
    pop_check("abort_head1", 6'd1);
    pop_check("abort_head2", 6'd2);

    // reset while waiting on the second round of a 7..9 sweep
    pulse_go(6'd7, 6'd9);
    wait_for(1, 1, 100, "rstw_first_entry");
    wait_for(2, 0, 50, "rstw_wait_state");
    chk("rstw_in_wait", fsm_state, WAIT);
    sync_rst_in = 1'b1;
    tick();
    check_reset_values("rstw");
    sync_rst_in = 1'b0;
    tick();

`ifdef GPS_SEQ_TIMEOUT_EN
    // GPS never answers: every round times out and the sweep still completes
    gps_mute = 1'b1;
    res_rd = 1'b1;
    pulse_go(6'd3, 6'd4);
    collect(400);
    res_rd = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("to_err", (i < err_q.size()) ? err_q[i] : 1'bx, 1'b1);
      chk("to_zero_codes", (i < code_q.size()) ? code_q[i] : 1'bx, 1'b0);
    end
    exp_q = '{6'd3, 6'd4};
    check_q("to_order");
    gps_mute = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
